// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame writer.
// Stream framing bytes and record geometry live here.
package cfg_frame_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_COL,
        S_IDX,
        S_DATA,
        S_STROBE
    } state_t;

    localparam logic [7:0] SYNC_BYTE         = 8'hA5;
    localparam logic [7:0] END_COL           = 8'hFF;
    localparam int         RECORD_DATA_BYTES = 4;

endpackage

// File: rtl/cfg_byte_packer.sv
// MSB-first 4-byte packer; o_word presents the full word including
// the byte currently on i_byte so the FSM can load it on the last beat.
module cfg_byte_packer
    import cfg_frame_pkg::*;
(
    input  logic        CLK,
    input  logic        resetn,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last,
    output logic        o_full
);

    logic [23:0] r_word;
    logic [1:0]  r_cnt;
    logic        r_full;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_en && !r_full) begin
            r_word <= {r_word[15:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
            if (o_last)
                r_full <= 1'b1;
        end
    end

    assign o_word = {r_word, i_byte};
    assign o_last = (r_cnt == 2'(RECORD_DATA_BYTES - 1));
    assign o_full = r_full;

endmodule

// File: rtl/config_frame_writer.sv
// Byte-stream to configuration-frame writer: sync hunt, record parsing,
// range checks and registered one-hot frame strobes.
module config_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 16
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [FrameBitsPerRow-1:0]    FrameData,
    output logic [$clog2(NumColumns)-1:0] FrameCol,
    output logic [MaxFramesPerCol-1:0]    FrameStrobe,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [15:0]                   frame_count
);

    localparam int CW = $clog2(NumColumns);
    localparam int IW = $clog2(MaxFramesPerCol);

    state_t                     r_state;
    logic [CW-1:0]              r_col;
    logic [IW-1:0]              r_idx;
    logic                       r_bad;
    logic [FrameBitsPerRow-1:0] r_frame_data;
    logic [CW-1:0]              r_frame_col;
    logic [MaxFramesPerCol-1:0] r_strobe;
    logic                       r_done;
    logic                       r_err;
    logic [15:0]                r_count;

    logic [31:0]                w_word;
    logic                       w_last;
    logic                       w_full;
    logic                       w_clr;
    logic                       w_en;
    logic                       w_col_bad;
    logic                       w_idx_bad;
    logic [MaxFramesPerCol-1:0] w_onehot;

    assign s_ready   = (r_state != S_STROBE);
    assign busy      = (r_state != S_HUNT);
    assign w_clr     = (r_state == S_IDX);
    assign w_en      = (r_state == S_DATA) && s_valid && !w_full;
    assign w_col_bad = {24'd0, s_data} >= 32'(NumColumns);
    assign w_idx_bad = {24'd0, s_data} >= 32'(MaxFramesPerCol);
    assign w_onehot  = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_idx;

    cfg_byte_packer u_packer (
        .CLK    (CLK),
        .resetn (resetn),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_byte (s_data),
        .o_word (w_word),
        .o_last (w_last),
        .o_full (w_full)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_HUNT;
            r_col        <= '0;
            r_idx        <= '0;
            r_bad        <= 1'b0;
            r_frame_data <= '0;
            r_frame_col  <= '0;
            r_strobe     <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_count      <= '0;
        end else begin
            r_strobe <= '0;
            r_done   <= 1'b0;
            unique case (r_state)
                S_HUNT: begin
                    if (s_valid && s_data == SYNC_BYTE) begin
                        r_state <= S_COL;
                        r_err   <= 1'b0;
                        r_count <= '0;
                    end
                end
                S_COL: begin
                    if (s_valid) begin
                        if (s_data == END_COL) begin
                            r_done  <= 1'b1;
                            r_state <= S_HUNT;
                        end else begin
                            r_col   <= s_data[CW-1:0];
                            r_bad   <= w_col_bad;
                            r_state <= S_IDX;
                        end
                    end
                end
                S_IDX: begin
                    if (s_valid) begin
                        r_idx   <= s_data[IW-1:0];
                        r_bad   <= r_bad | w_idx_bad;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Load on the last beat so the strobe lands in the STROBE cycle.
                    if (s_valid && w_last) begin
                        r_state <= S_STROBE;
                        if (r_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_frame_data <= FrameBitsPerRow'(w_word);
                            r_frame_col  <= r_col;
                            r_strobe     <= w_onehot;
                            if (r_count != 16'hFFFF)
                                r_count <= r_count + 16'd1;
                        end
                    end
                end
                S_STROBE: begin
                    r_state <= S_COL;
                end
                default: begin
                    r_state <= S_HUNT;
                end
            endcase
        end
    end

    assign FrameData   = r_frame_data;
    assign FrameCol    = r_frame_col;
    assign FrameStrobe = r_strobe;
    assign done        = r_done;
    assign err         = r_err;
    assign frame_count = r_count;

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer: directed byte streams push
// expected strobe/done events; a negedge monitor pops and compares.
module tb_config_frame_writer;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] FrameData;
    logic [3:0]  FrameCol;
    logic [19:0] FrameStrobe;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] frame_count;

    config_frame_writer dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameCol    (FrameCol),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0] strobe;
        logic [3:0]  col;
        logic [31:0] data;
        logic [15:0] cnt;
        logic        err;
        logic        dn;
    } ev_t;

    ev_t         q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ready_low = 0;
    int          strobe_cyc[$];
    logic [31:0] m_data = 32'h0;
    logic [3:0]  m_col = 4'h0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic exp_strobe(input int col, input int idx,
                              input logic [31:0] d, input int cnt,
                              input logic e);
        ev_t x;
        x.strobe = 20'(1) << idx;
        x.col    = 4'(col);
        x.data   = d;
        x.cnt    = 16'(cnt);
        x.err    = e;
        x.dn     = 1'b0;
        q.push_back(x);
    endtask

    task automatic exp_done(input int col, input logic [31:0] d,
                            input int cnt, input logic e);
        ev_t x;
        x.strobe = '0;
        x.col    = 4'(col);
        x.data   = d;
        x.cnt    = 16'(cnt);
        x.err    = e;
        x.dn     = 1'b1;
        q.push_back(x);
    endtask

    always @(negedge CLK) begin
        ev_t e;
        cyc++;
        if (resetn) begin
            if (!s_ready)
                ready_low++;
            if (FrameStrobe != 0 || done) begin
                chk("strobe_done_excl", 32'(FrameStrobe != 0 && done), 32'd0);
                chk("strobe_onehot0", 32'($onehot0(FrameStrobe)), 32'd1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: strobe %h done %b expected none",
                             FrameStrobe, done);
                end else begin
                    e = q.pop_front();
                    chk("ev_strobe", FrameStrobe, e.strobe);
                    chk("ev_done", done, e.dn);
                    chk("ev_col", FrameCol, e.col);
                    chk("ev_data", FrameData, e.data);
                    chk("ev_count", frame_count, e.cnt);
                    chk("ev_err", err, e.err);
                    if (e.strobe != 0) begin
                        m_data = e.data;
                        m_col  = e.col;
                        strobe_cyc.push_back(cyc);
                    end
                end
            end else begin
                chk("held_data", FrameData, m_data);
                chk("held_col", FrameCol, m_col);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        @(negedge CLK);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: s_ready %b expected 1", s_ready);
        end
        @(posedge CLK);
        if (gap) begin
            @(negedge CLK);
            s_valid = 1'b0;
        end
    endtask

    task automatic send_rec(input logic [7:0] col, input logic [7:0] idx,
                            input logic [31:0] d, input bit gap);
        send(col, gap);
        send(idx, gap);
        send(d[31:24], gap);
        send(d[23:16], gap);
        send(d[15:8], gap);
        send(d[7:0], gap);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        s_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, FrameData, 0);
        chk({tag, "_col"}, FrameCol, 0);
        chk({tag, "_strobe"}, FrameStrobe, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_count"}, frame_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        repeat (2) @(negedge CLK);
        chk_reset_state("rst");
        resetn = 1'b1;

        // Single record write
        exp_strobe(3, 7, 32'hDEADBEEF, 1, 0);
        exp_done(3, 32'hDEADBEEF, 1, 0);
        send(8'hA5, 0);
        send_rec(8'h03, 8'h07, 32'hDEADBEEF, 0);
        send(8'hFF, 0);
        idle(3);
        chk("t1_busy", busy, 0);
        chk("t1_count", frame_count, 1);

        // Hunt garbage, bad index, then a good record
        send(8'h00, 0);
        send(8'h5A, 0);
        idle(1);
        chk("t2_hunt_busy", busy, 0);
        exp_strobe(1, 0, 32'h55667788, 1, 1);
        exp_done(1, 32'h55667788, 1, 1);
        send(8'hA5, 0);
        send_rec(8'h02, 8'h14, 32'h11223344, 0);
        @(negedge CLK);
        chk("t2_bad_err", err, 1);
        chk("t2_bad_strobe", FrameStrobe, 0);
        chk("t2_bad_ready", s_ready, 0);
        chk("t2_bad_data", FrameData, 32'hDEADBEEF);
        chk("t2_bad_count", frame_count, 0);
        send_rec(8'h01, 8'h00, 32'h55667788, 0);
        send(8'hFF, 0);
        idle(3);
        chk("t2_err_sticky", err, 1);
        send(8'hA5, 0);
        idle(2);
        chk("t2_err_clear", err, 0);
        chk("t2_count_clear", frame_count, 0);
        chk("t2_busy", busy, 1);
        exp_done(1, 32'h55667788, 0, 0);
        send(8'hFF, 0);
        idle(3);

        // Gapped valid
        ready_low = 0;
        exp_strobe(3, 7, 32'hDEADBEEF, 1, 0);
        exp_done(3, 32'hDEADBEEF, 1, 0);
        send(8'hA5, 1);
        send_rec(8'h03, 8'h07, 32'hDEADBEEF, 1);
        send(8'hFF, 1);
        idle(3);
        chk("t3_ready_low", ready_low, 1);
        chk("t3_busy", busy, 0);

        // Back-to-back records
        strobe_cyc.delete();
        exp_strobe(0, 0, 32'h01020304, 1, 0);
        exp_strobe(15, 19, 32'hCAFEF00D, 2, 0);
        exp_strobe(5, 10, 32'h12345678, 3, 0);
        exp_done(5, 32'h12345678, 3, 0);
        send(8'hA5, 0);
        send_rec(8'h00, 8'h00, 32'h01020304, 0);
        send_rec(8'h0F, 8'h13, 32'hCAFEF00D, 0);
        send_rec(8'h05, 8'h0A, 32'h12345678, 0);
        send(8'hFF, 0);
        idle(3);
        chk("t4_nstrobes", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            chk("t4_gap1", strobe_cyc[1] - strobe_cyc[0], 7);
            chk("t4_gap2", strobe_cyc[2] - strobe_cyc[1], 7);
        end
        chk("t4_count", frame_count, 3);

        // Data bytes equal to sync
        exp_strobe(6, 2, 32'hA5A5A5A5, 1, 0);
        exp_strobe(9, 3, 32'h00000001, 2, 0);
        exp_done(9, 32'h00000001, 2, 0);
        send(8'hA5, 0);
        send_rec(8'h06, 8'h02, 32'hA5A5A5A5, 0);
        send_rec(8'h09, 8'h03, 32'h00000001, 0);
        send(8'hFF, 0);
        idle(3);

        // Reset mid-record
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        @(negedge CLK);
        resetn  = 1'b0;
        s_valid = 1'b0;
        m_data  = 32'h0;
        m_col   = 4'h0;
        #1;
        chk_reset_state("mid");
        @(negedge CLK);
        resetn = 1'b1;
        exp_strobe(4, 1, 32'h01234567, 1, 0);
        exp_done(4, 32'h01234567, 1, 0);
        send(8'hA5, 0);
        send_rec(8'h04, 8'h01, 32'h01234567, 0);
        send(8'hFF, 0);
        idle(5);

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
